tilemap_layer_mixer: RTL and testbench



---
 rtl/tilemap_layer_mixer.sv | 118 +++++++++++
 tb/tb_tilemap_layer_mixer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilemap_layer_mixer.sv
// Tilemap layer mixer: aligns per-tile attributes with their pixels through
// programmable delay lines and merges layers A, B and OBJ into one colour code.
module tilemap_layer_mixer #(
    parameter int A_ATTR_DLY = 5,
    parameter int B_ATTR_DLY = 2
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_RST_n,
    input  logic        i_EMU_CLK6MPCEN_n,
    input  logic [3:0]  i_A_PIXEL,
    input  logic        i_A_TRN_n,
    input  logic [3:0]  i_B_PIXEL,
    input  logic        i_B_TRN_n,
    input  logic [7:0]  i_A_ATTR,
    input  logic        i_A_ATTR_LD,
    input  logic [7:0]  i_B_ATTR,
    input  logic        i_B_ATTR_LD,
    input  logic [3:0]  i_OBJ_PIXEL,
    input  logic [6:0]  i_OBJ_PAL,
    input  logic [2:0]  i_LAYER_EN,
    input  logic        i_BLANK_n,
    output logic [10:0] o_CD,
    output logic [1:0]  o_SRC
);

    typedef enum logic [1:0] {
        SRC_BACKDROP = 2'b00,
        SRC_A        = 2'b01,
        SRC_B        = 2'b10,
        SRC_OBJ      = 2'b11
    } src_t;

    logic       cen;
    logic [8:0] a_line [A_ATTR_DLY];
    logic [8:0] b_line [B_ATTR_DLY];
    logic [7:0] attr_a, attr_b;
    logic [7:0] attr_a_eff, attr_b_eff;
    logic       a_op, b_op, o_op;
    src_t       src_nxt, src_q;
    logic [10:0] cd_nxt;

    assign cen = ~i_EMU_CLK6MPCEN_n;

    // A landing attribute bypasses the register so it governs this cycle's pixel.
    assign attr_a_eff = a_line[A_ATTR_DLY-1][8] ? a_line[A_ATTR_DLY-1][7:0] : attr_a;
    assign attr_b_eff = b_line[B_ATTR_DLY-1][8] ? b_line[B_ATTR_DLY-1][7:0] : attr_b;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the shift.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            // NOTE: the delay line is reset on purpose: in-flight strobes must be
            // discarded so no stale attribute lands after reset is released.
            for (int i = 0; i < A_ATTR_DLY; i++) a_line[i] <= '0;
            attr_a <= '0;
        end else if (cen) begin
            a_line[0] <= {i_A_ATTR_LD, i_A_ATTR};
            for (int i = 1; i < A_ATTR_DLY; i++) a_line[i] <= a_line[i-1];
            attr_a <= attr_a_eff;
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            for (int i = 0; i < B_ATTR_DLY; i++) b_line[i] <= '0;
            attr_b <= '0;
        end else if (cen) begin
            b_line[0] <= {i_B_ATTR_LD, i_B_ATTR};
            for (int i = 1; i < B_ATTR_DLY; i++) b_line[i] <= b_line[i-1];
            attr_b <= attr_b_eff;
        end
    end

    assign a_op = i_A_TRN_n & i_LAYER_EN[0];
    assign b_op = i_B_TRN_n & i_LAYER_EN[1];
    assign o_op = (i_OBJ_PIXEL != 4'h0) & i_LAYER_EN[2];

    // NOTE: defaults first, so no path through this block leaves a value unassigned
    // and no latch is inferred.
    always_comb begin
        src_nxt = SRC_BACKDROP;
        cd_nxt  = 11'h000;
        if (a_op && attr_a_eff[7]) begin
            src_nxt = SRC_A;
            cd_nxt  = {attr_a_eff[6:0], i_A_PIXEL};
        end else if (b_op && attr_b_eff[7]) begin
            src_nxt = SRC_B;
            cd_nxt  = {attr_b_eff[6:0], i_B_PIXEL};
        end else if (o_op) begin
            src_nxt = SRC_OBJ;
            cd_nxt  = {i_OBJ_PAL, i_OBJ_PIXEL};
        end else if (a_op) begin
            src_nxt = SRC_A;
            cd_nxt  = {attr_a_eff[6:0], i_A_PIXEL};
        end else if (b_op) begin
            src_nxt = SRC_B;
            cd_nxt  = {attr_b_eff[6:0], i_B_PIXEL};
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            src_q <= SRC_BACKDROP;
            o_CD  <= 11'h000;
        end else if (cen) begin
            if (!i_BLANK_n) begin
                src_q <= SRC_BACKDROP;
                o_CD  <= 11'h000;
            end else begin
                src_q <= src_nxt;
                o_CD  <= cd_nxt;
            end
        end
    end

    assign o_SRC = src_q;

endmodule

// File: tb/tb_tilemap_layer_mixer.sv
// Directed self-checking bench for tilemap_layer_mixer (A_ATTR_DLY=5, B_ATTR_DLY=2).
module tb_tilemap_layer_mixer;

    logic        i_EMU_MCLK;
    logic        i_EMU_RST_n;
    logic        i_EMU_CLK6MPCEN_n;
    logic [3:0]  i_A_PIXEL;
    logic        i_A_TRN_n;
    logic [3:0]  i_B_PIXEL;
    logic        i_B_TRN_n;
    logic [7:0]  i_A_ATTR;
    logic        i_A_ATTR_LD;
    logic [7:0]  i_B_ATTR;
    logic        i_B_ATTR_LD;
    logic [3:0]  i_OBJ_PIXEL;
    logic [6:0]  i_OBJ_PAL;
    logic [2:0]  i_LAYER_EN;
    logic        i_BLANK_n;
    logic [10:0] o_CD;
    logic [1:0]  o_SRC;

    int checks = 0;
    int errors = 0;

    tilemap_layer_mixer #(
        .A_ATTR_DLY(5),
        .B_ATTR_DLY(2)
    ) dut (
        .i_EMU_MCLK        (i_EMU_MCLK),
        .i_EMU_RST_n       (i_EMU_RST_n),
        .i_EMU_CLK6MPCEN_n (i_EMU_CLK6MPCEN_n),
        .i_A_PIXEL         (i_A_PIXEL),
        .i_A_TRN_n         (i_A_TRN_n),
        .i_B_PIXEL         (i_B_PIXEL),
        .i_B_TRN_n         (i_B_TRN_n),
        .i_A_ATTR          (i_A_ATTR),
        .i_A_ATTR_LD       (i_A_ATTR_LD),
        .i_B_ATTR          (i_B_ATTR),
        .i_B_ATTR_LD       (i_B_ATTR_LD),
        .i_OBJ_PIXEL       (i_OBJ_PIXEL),
        .i_OBJ_PAL         (i_OBJ_PAL),
        .i_LAYER_EN        (i_LAYER_EN),
        .i_BLANK_n         (i_BLANK_n),
        .o_CD              (o_CD),
        .o_SRC             (o_SRC)
    );

    initial begin
        i_EMU_MCLK = 1'b0;
        forever #5 i_EMU_MCLK = ~i_EMU_MCLK;
    end

    // One clock, sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge i_EMU_MCLK);
        #1;
    endtask

    // Strobe attributes on one enable cycle, then wait until the longest line lands.
    task automatic load_attr(input logic a_ld, input logic [7:0] a,
                             input logic b_ld, input logic [7:0] b);
        i_A_ATTR_LD = a_ld; i_A_ATTR = a;
        i_B_ATTR_LD = b_ld; i_B_ATTR = b;
        cyc();
        i_A_ATTR_LD = 1'b0; i_B_ATTR_LD = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b00, 11'h000}) begin
            errors++;
            $display("FAIL reset_hold: got src=%b cd=%h, expected src=00 cd=000", o_SRC, o_CD);
        end
        i_EMU_RST_n = 1'b1;
        i_LAYER_EN = 3'b111; i_BLANK_n = 1'b1;
        i_A_PIXEL = 4'h3; i_A_TRN_n = 1'b1;
        i_A_ATTR = 8'h7F; i_A_ATTR_LD = 1'b1;
        cyc();
        i_A_ATTR_LD = 1'b0;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b01, 11'h003}) begin
            errors++;
            $display("FAIL pre_reset_active: got src=%b cd=%h, expected src=01 cd=003", o_SRC, o_CD);
        end
        #2 i_EMU_RST_n = 1'b0;
        #1;
        checks++;
        if ({o_SRC, o_CD} !== {2'b00, 11'h000}) begin
            errors++;
            $display("FAIL reset_async: got src=%b cd=%h, expected src=00 cd=000", o_SRC, o_CD);
        end
        #1 i_EMU_RST_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++;
            if ({o_SRC, o_CD} !== {2'b01, 11'h003}) begin
                errors++;
                $display("FAIL no_late_attr[%0d]: got src=%b cd=%h, expected src=01 cd=003", k, o_SRC, o_CD);
            end
        end
    endtask

    task automatic test_a_align();
        logic [10:0] exp_cd;
        i_A_PIXEL = 4'h3; i_A_TRN_n = 1'b1;
        i_B_TRN_n = 1'b0; i_OBJ_PIXEL = 4'h0;
        for (int k = 0; k < 10; k++) begin
            i_A_ATTR = 8'h25;
            i_A_ATTR_LD = (k == 0);
            cyc();
            exp_cd = (k >= 5) ? 11'h253 : 11'h003;
            checks++;
            if ({o_SRC, o_CD} !== {2'b01, exp_cd}) begin
                errors++;
                $display("FAIL a_align[%0d]: got src=%b cd=%h, expected src=01 cd=%h", k, o_SRC, o_CD, exp_cd);
            end
        end
        i_A_ATTR_LD = 1'b0;
    endtask

    task automatic test_priority();
        load_attr(1'b1, 8'h81, 1'b1, 8'h02);
        i_A_PIXEL = 4'h5; i_A_TRN_n = 1'b1;
        i_B_PIXEL = 4'h6; i_B_TRN_n = 1'b1;
        i_OBJ_PIXEL = 4'h7; i_OBJ_PAL = 7'h10;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b01, 11'h015}) begin
            errors++;
            $display("FAIL prio_a_high: got src=%b cd=%h, expected src=01 cd=015", o_SRC, o_CD);
        end
        load_attr(1'b1, 8'h01, 1'b0, 8'h00);
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b11, 11'h107}) begin
            errors++;
            $display("FAIL prio_obj: got src=%b cd=%h, expected src=11 cd=107", o_SRC, o_CD);
        end
        i_OBJ_PIXEL = 4'h0;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b01, 11'h015}) begin
            errors++;
            $display("FAIL prio_a_low: got src=%b cd=%h, expected src=01 cd=015", o_SRC, o_CD);
        end
        i_A_TRN_n = 1'b0;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b10, 11'h026}) begin
            errors++;
            $display("FAIL prio_b_low: got src=%b cd=%h, expected src=10 cd=026", o_SRC, o_CD);
        end
        load_attr(1'b0, 8'h00, 1'b1, 8'h82);
        i_A_TRN_n = 1'b1; i_OBJ_PIXEL = 4'h7;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b10, 11'h026}) begin
            errors++;
            $display("FAIL prio_b_high: got src=%b cd=%h, expected src=10 cd=026", o_SRC, o_CD);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_cd;
        i_A_TRN_n = 1'b0; i_OBJ_PIXEL = 4'h0;
        i_B_PIXEL = 4'h9; i_B_TRN_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_B_ATTR_LD = (k < 3);
            i_B_ATTR = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'h33;
            cyc();
            case (k)
                0, 1:    exp_cd = 11'h029;
                2:       exp_cd = 11'h119;
                3:       exp_cd = 11'h229;
                default: exp_cd = 11'h339;
            endcase
            checks++;
            if ({o_SRC, o_CD} !== {2'b10, exp_cd}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got src=%b cd=%h, expected src=10 cd=%h", k, o_SRC, o_CD, exp_cd);
            end
        end
        i_B_ATTR_LD = 1'b0;
    endtask

    task automatic test_blank_enables();
        i_BLANK_n = 1'b0;
        i_A_PIXEL = 4'h5; i_A_TRN_n = 1'b1;
        i_B_PIXEL = 4'h6; i_B_TRN_n = 1'b1;
        i_OBJ_PIXEL = 4'h7; i_OBJ_PAL = 7'h10;
        for (int k = 0; k < 7; k++) begin
            i_A_ATTR = 8'h44;
            i_A_ATTR_LD = (k == 0);
            cyc();
            checks++;
            if ({o_SRC, o_CD} !== {2'b00, 11'h000}) begin
                errors++;
                $display("FAIL blank[%0d]: got src=%b cd=%h, expected src=00 cd=000", k, o_SRC, o_CD);
            end
        end
        i_A_ATTR_LD = 1'b0;
        i_BLANK_n = 1'b1; i_OBJ_PIXEL = 4'h0;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b01, 11'h445}) begin
            errors++;
            $display("FAIL blank_strobe_applied: got src=%b cd=%h, expected src=01 cd=445", o_SRC, o_CD);
        end
        i_LAYER_EN = 3'b011; i_OBJ_PIXEL = 4'h7;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b01, 11'h445}) begin
            errors++;
            $display("FAIL en_obj_off_a: got src=%b cd=%h, expected src=01 cd=445", o_SRC, o_CD);
        end
        i_A_TRN_n = 1'b0; i_B_TRN_n = 1'b0;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b00, 11'h000}) begin
            errors++;
            $display("FAIL en_obj_off_bg: got src=%b cd=%h, expected src=00 cd=000", o_SRC, o_CD);
        end
        i_LAYER_EN = 3'b110; i_A_TRN_n = 1'b1; i_OBJ_PIXEL = 4'h0;
        cyc();
        checks++;
        if ({o_SRC, o_CD} !== {2'b00, 11'h000}) begin
            errors++;
            $display("FAIL en_a_off: got src=%b cd=%h, expected src=00 cd=000", o_SRC, o_CD);
        end
        i_LAYER_EN = 3'b111;
    endtask

    task automatic test_clock_enable();
        logic [10:0] exp_cd;
        i_A_PIXEL = 4'h5; i_A_TRN_n = 1'b1;
        i_B_TRN_n = 1'b0; i_OBJ_PIXEL = 4'h0;
        for (int k = 0; k < 2; k++) begin
            i_A_ATTR = 8'h66;
            i_A_ATTR_LD = (k == 0);
            cyc();
            checks++;
            if ({o_SRC, o_CD} !== {2'b01, 11'h445}) begin
                errors++;
                $display("FAIL cen_pre[%0d]: got src=%b cd=%h, expected src=01 cd=445", k, o_SRC, o_CD);
            end
        end
        i_EMU_CLK6MPCEN_n = 1'b1;
        i_A_PIXEL = 4'hF; i_A_ATTR = 8'h77; i_A_ATTR_LD = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if ({o_SRC, o_CD} !== {2'b01, 11'h445}) begin
                errors++;
                $display("FAIL cen_frozen[%0d]: got src=%b cd=%h, expected src=01 cd=445", k, o_SRC, o_CD);
            end
        end
        i_EMU_CLK6MPCEN_n = 1'b0;
        i_A_PIXEL = 4'h5; i_A_ATTR_LD = 1'b0;
        for (int k = 2; k < 7; k++) begin
            cyc();
            exp_cd = (k >= 5) ? 11'h665 : 11'h445;
            checks++;
            if ({o_SRC, o_CD} !== {2'b01, exp_cd}) begin
                errors++;
                $display("FAIL cen_resume[%0d]: got src=%b cd=%h, expected src=01 cd=%h", k, o_SRC, o_CD, exp_cd);
            end
        end
    endtask

    initial begin
        i_EMU_RST_n = 1'b0;
        i_EMU_CLK6MPCEN_n = 1'b0;
        i_A_PIXEL = 4'h0; i_A_TRN_n = 1'b0;
        i_B_PIXEL = 4'h0; i_B_TRN_n = 1'b0;
        i_A_ATTR = 8'h00; i_A_ATTR_LD = 1'b0;
        i_B_ATTR = 8'h00; i_B_ATTR_LD = 1'b0;
        i_OBJ_PIXEL = 4'h0; i_OBJ_PAL = 7'h00;
        i_LAYER_EN = 3'b111; i_BLANK_n = 1'b1;

        test_reset();
        test_a_align();
        test_priority();
        test_back_to_back();
        test_blank_enables();
        test_clock_enable();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
